// File: rtl/io_reg_route_pkg.sv
// Shared types and widths for the io_reg route mux slice.
package io_reg_route_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    COMMIT
  } state_e;

  localparam int unsigned HOLD_CNT_W   = 8;
  localparam int unsigned SWITCH_CNT_W = 16;
  localparam int unsigned MAX_INPUTS   = 16;

endpackage

// File: rtl/io_reg_route_sel_fsm.sv
// Route-select controller: request handshake, hold/commit sequencing and the sticky error flag.
// Define IO_REG_ROUTE_MUX_CNT_EN to add the saturating committed-switch counter.
module io_reg_route_sel_fsm
  import io_reg_route_pkg::*;
#(
  parameter int unsigned NUM_INPUTS  = 2,
  parameter int unsigned RESET_SEL   = 0,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned SEL_W       = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    sel_valid_i,
  input  logic [SEL_W-1:0]        sel_idx_i,
  input  logic                    err_clr_i,
  output logic                    sel_ready_o,
  output logic [SEL_W-1:0]        sel_cur_o,
  output logic                    switching_o,
`ifdef IO_REG_ROUTE_MUX_CNT_EN
  output logic [SWITCH_CNT_W-1:0] switch_cnt_o,
`endif
  output logic                    sel_err_o
);

  localparam logic [SEL_W-1:0] ResetSel = SEL_W'(RESET_SEL);
  // Counter preload; HOLD is skipped entirely when HOLD_CYCLES is zero.
  localparam logic [HOLD_CNT_W-1:0] HoldInit =
      (HOLD_CYCLES > 0) ? HOLD_CNT_W'(HOLD_CYCLES - 1) : '0;

  state_e                  state_q;
  logic [HOLD_CNT_W-1:0]   hold_cnt_q;
  logic [SEL_W-1:0]        pending_q;
  logic [SEL_W-1:0]        sel_cur_q;
  logic                    sel_err_q;
  logic                    idx_oob;
`ifdef IO_REG_ROUTE_MUX_CNT_EN
  logic [SWITCH_CNT_W-1:0] switch_cnt_q;
`endif

  assign idx_oob = (32'(sel_idx_i) >= NUM_INPUTS);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      pending_q    <= ResetSel;
      sel_cur_q    <= ResetSel;
      sel_err_q    <= 1'b0;
`ifdef IO_REG_ROUTE_MUX_CNT_EN
      switch_cnt_q <= '0;
`endif
    end else begin
      // Set below overrides this clear when both happen on one edge.
      if (err_clr_i) sel_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sel_valid_i) begin
            if (idx_oob) begin
              sel_err_q <= 1'b1;
            end else if (sel_idx_i != sel_cur_q) begin
              pending_q <= sel_idx_i;
              if (HOLD_CYCLES > 0) begin
                hold_cnt_q <= HoldInit;
                state_q    <= HOLD;
              end else begin
                state_q <= COMMIT;
              end
            end
          end
        end
        HOLD: begin
          if (hold_cnt_q == '0) state_q <= COMMIT;
          else hold_cnt_q <= hold_cnt_q - HOLD_CNT_W'(1);
        end
        COMMIT: begin
          sel_cur_q <= pending_q;
          state_q   <= IDLE;
`ifdef IO_REG_ROUTE_MUX_CNT_EN
          if (switch_cnt_q != '1) switch_cnt_q <= switch_cnt_q + SWITCH_CNT_W'(1);
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel_ready_o  = (state_q == IDLE);
  assign switching_o  = (state_q != IDLE);
  assign sel_cur_o    = sel_cur_q;
  assign sel_err_o    = sel_err_q;
`ifdef IO_REG_ROUTE_MUX_CNT_EN
  assign switch_cnt_o = switch_cnt_q;
`endif

endmodule

// File: rtl/io_reg_route_mux.sv
// N-input routing mux into a clock-enabled output register, with glitch-free runtime re-routing.
// Define IO_REG_ROUTE_MUX_CNT_EN to expose the switch_cnt port.
module io_reg_route_mux
  import io_reg_route_pkg::*;
#(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned NUM_INPUTS  = 2,
  parameter int unsigned RESET_SEL   = 0,
  parameter int unsigned HOLD_CYCLES = 2,
  localparam int unsigned SEL_W      = $clog2(NUM_INPUTS)
) (
  input  logic                        QCK,
  input  logic                        QRT,
  input  logic                        QEN,
  input  logic [NUM_INPUTS*WIDTH-1:0] I,
  input  logic                        sel_valid,
  input  logic [SEL_W-1:0]            sel_idx,
  output logic                        sel_ready,
  input  logic                        err_clr,
  output logic [WIDTH-1:0]            O,
  output logic [SEL_W-1:0]            sel_cur,
  output logic                        switching,
`ifdef IO_REG_ROUTE_MUX_CNT_EN
  output logic [SWITCH_CNT_W-1:0]     switch_cnt,
`endif
  output logic                        sel_err
);

  logic [WIDTH-1:0] mux_d;
  logic [WIDTH-1:0] o_q;

  io_reg_route_sel_fsm #(
    .NUM_INPUTS  (NUM_INPUTS),
    .RESET_SEL   (RESET_SEL),
    .HOLD_CYCLES (HOLD_CYCLES),
    .SEL_W       (SEL_W)
  ) u_sel_fsm (
    .clk_i        (QCK),
    .rst_i        (QRT),
    .sel_valid_i  (sel_valid),
    .sel_idx_i    (sel_idx),
    .err_clr_i    (err_clr),
    .sel_ready_o  (sel_ready),
    .sel_cur_o    (sel_cur),
    .switching_o  (switching),
`ifdef IO_REG_ROUTE_MUX_CNT_EN
    .switch_cnt_o (switch_cnt),
`endif
    .sel_err_o    (sel_err)
  );

  always_comb begin
    mux_d = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (sel_cur == SEL_W'(k)) mux_d = I[k*WIDTH +: WIDTH];
    end
  end

  // O is frozen for the whole hold/commit window so the route change never glitches it.
  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      o_q <= '0;
    end else if (QEN && !switching) begin
      o_q <= mux_d;
    end
  end

  assign O = o_q;

endmodule

// File: tb/tb_io_reg_route_mux.sv
// Directed bench for io_reg_route_mux: a 4-input H=2 instance and a 3-input H=0 instance.
module tb_io_reg_route_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: WIDTH=8, NUM_INPUTS=4, RESET_SEL=1, HOLD_CYCLES=2
  logic        rst_a, qen_a, sv_a, ec_a, rdy_a, sw_a, err_a;
  logic [31:0] i_a;
  logic [1:0]  si_a, cur_a;
  logic [7:0]  o_a;
  // Instance B: WIDTH=8, NUM_INPUTS=3, RESET_SEL=0, HOLD_CYCLES=0
  logic        rst_b, qen_b, sv_b, ec_b, rdy_b, sw_b, err_b;
  logic [23:0] i_b;
  logic [1:0]  si_b, cur_b;
  logic [7:0]  o_b;
`ifdef IO_REG_ROUTE_MUX_CNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  io_reg_route_mux #(
    .WIDTH       (8),
    .NUM_INPUTS  (4),
    .RESET_SEL   (1),
    .HOLD_CYCLES (2)
  ) dut_a (
    .QCK        (clk),
    .QRT        (rst_a),
    .QEN        (qen_a),
    .I          (i_a),
    .sel_valid  (sv_a),
    .sel_idx    (si_a),
    .sel_ready  (rdy_a),
    .err_clr    (ec_a),
    .O          (o_a),
    .sel_cur    (cur_a),
    .switching  (sw_a),
`ifdef IO_REG_ROUTE_MUX_CNT_EN
    .switch_cnt (cnt_a),
`endif
    .sel_err    (err_a)
  );

  io_reg_route_mux #(
    .WIDTH       (8),
    .NUM_INPUTS  (3),
    .RESET_SEL   (0),
    .HOLD_CYCLES (0)
  ) dut_b (
    .QCK        (clk),
    .QRT        (rst_b),
    .QEN        (qen_b),
    .I          (i_b),
    .sel_valid  (sv_b),
    .sel_idx    (si_b),
    .sel_ready  (rdy_b),
    .err_clr    (ec_b),
    .O          (o_b),
    .sel_cur    (cur_b),
    .switching  (sw_b),
`ifdef IO_REG_ROUTE_MUX_CNT_EN
    .switch_cnt (cnt_b),
`endif
    .sel_err    (err_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; qen_a = 1'b1; sv_a = 1'b0; si_a = 2'd0; ec_a = 1'b0;
    i_a   = {8'h3C, 8'h22, 8'hA5, 8'h00};
    rst_b = 1'b1; qen_b = 1'b1; sv_b = 1'b0; si_b = 2'd0; ec_b = 1'b0;
    i_b   = {8'hC3, 8'hB2, 8'hA1};

    // Reset state
    #2;
    check_eq("a_rst_o", 32'(o_a), 32'h00);
    check_eq("a_rst_cur", 32'(cur_a), 32'd1);
    check_eq("a_rst_rdy", 32'(rdy_a), 32'd1);
    check_eq("a_rst_sw", 32'(sw_a), 32'd0);
    check_eq("a_rst_err", 32'(err_a), 32'd0);
    check_eq("b_rst_cur", 32'(cur_b), 32'd0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    check_eq("a_o_before_edge", 32'(o_a), 32'h00);
    tick();
    check_eq("a_o_first", 32'(o_a), 32'hA5);
    check_eq("a_cur_first", 32'(cur_a), 32'd1);
    check_eq("b_o_first", 32'(o_b), 32'hA1);

    // Switch A to source 3 with H=2; source 1 keeps changing
    i_a[15:8] = 8'h11; sv_a = 1'b1; si_a = 2'd3;
    tick();  // edge k
    sv_a = 1'b0;
    check_eq("a_k_o", 32'(o_a), 32'h11);
    check_eq("a_k_rdy", 32'(rdy_a), 32'd0);
    check_eq("a_k_sw", 32'(sw_a), 32'd1);
    i_a[15:8] = 8'h44;
    tick();  // k+1
    check_eq("a_k1_o", 32'(o_a), 32'h11);
    check_eq("a_k1_rdy", 32'(rdy_a), 32'd0);
    tick();  // k+2: COMMIT cycle
    check_eq("a_k2_o", 32'(o_a), 32'h11);
    check_eq("a_k2_cur", 32'(cur_a), 32'd1);
    check_eq("a_k2_sw", 32'(sw_a), 32'd1);
    tick();  // k+3
    check_eq("a_k3_cur", 32'(cur_a), 32'd3);
    check_eq("a_k3_rdy", 32'(rdy_a), 32'd1);
    check_eq("a_k3_sw", 32'(sw_a), 32'd0);
    check_eq("a_k3_o", 32'(o_a), 32'h11);
    tick();  // k+4
    check_eq("a_k4_o", 32'(o_a), 32'h3C);

    // QEN low freezes O
    qen_a = 1'b0; i_a[31:24] = 8'h5A;
    tick();
    check_eq("a_qen0_o", 32'(o_a), 32'h3C);
    qen_a = 1'b1;
    tick();
    check_eq("a_qen1_o", 32'(o_a), 32'h5A);

    // No-op request to the current route
    sv_a = 1'b1; si_a = 2'd3;
    tick();
    sv_a = 1'b0;
    check_eq("a_noop_sw", 32'(sw_a), 32'd0);
    check_eq("a_noop_rdy", 32'(rdy_a), 32'd1);
    check_eq("a_noop_cur", 32'(cur_a), 32'd3);

    // Asynchronous reset during HOLD
    i_a[7:0] = 8'h77; sv_a = 1'b1; si_a = 2'd0;
    tick();
    sv_a = 1'b0;
    check_eq("a_mid_sw", 32'(sw_a), 32'd1);
    tick();
    #2;
    rst_a = 1'b1;
    #1;
    check_eq("a_async_o", 32'(o_a), 32'h00);
    check_eq("a_async_cur", 32'(cur_a), 32'd1);
    check_eq("a_async_sw", 32'(sw_a), 32'd0);
    check_eq("a_async_rdy", 32'(rdy_a), 32'd1);
`ifdef IO_REG_ROUTE_MUX_CNT_EN
    check_eq("a_async_cnt", 32'(cnt_a), 32'd0);
`endif
    @(posedge clk); #1;
    rst_a = 1'b0;
    tick();
    check_eq("a_post_rst_o", 32'(o_a), 32'h44);
    tick();
    check_eq("a_post_rst_sw", 32'(sw_a), 32'd0);
    check_eq("a_post_rst_cur", 32'(cur_a), 32'd1);

    // B: out-of-range request
    sv_b = 1'b1; si_b = 2'd3;
    tick();
    sv_b = 1'b0;
    check_eq("b_oob_err", 32'(err_b), 32'd1);
    check_eq("b_oob_cur", 32'(cur_b), 32'd0);
    check_eq("b_oob_sw", 32'(sw_b), 32'd0);
    i_b[7:0] = 8'hD4;
    tick();
    check_eq("b_oob_track", 32'(o_b), 32'hD4);
    ec_b = 1'b1; sv_b = 1'b1; si_b = 2'd3;
    tick();
    sv_b = 1'b0;
    check_eq("b_clr_vs_set", 32'(err_b), 32'd1);
    tick();
    ec_b = 1'b0;
    check_eq("b_clr", 32'(err_b), 32'd0);
`ifdef IO_REG_ROUTE_MUX_CNT_EN
    check_eq("b_cnt0", 32'(cnt_b), 32'd0);
`endif

    // B: H=0 switches 0->2->1->0
    sv_b = 1'b1; si_b = 2'd2;
    tick();
    sv_b = 1'b0;
    check_eq("b_s1_commit", 32'(sw_b), 32'd1);
    check_eq("b_s1_rdy", 32'(rdy_b), 32'd0);
    tick();
    check_eq("b_s1_cur", 32'(cur_b), 32'd2);
    check_eq("b_s1_sw", 32'(sw_b), 32'd0);
    tick();
    check_eq("b_s1_o", 32'(o_b), 32'hC3);
    sv_b = 1'b1; si_b = 2'd1;
    tick();
    sv_b = 1'b0;
    check_eq("b_s2_commit", 32'(sw_b), 32'd1);
    tick();
    check_eq("b_s2_cur", 32'(cur_b), 32'd1);
    sv_b = 1'b1; si_b = 2'd0;
    tick();
    sv_b = 1'b0;
    check_eq("b_s3_commit", 32'(sw_b), 32'd1);
    tick();
    check_eq("b_s3_cur", 32'(cur_b), 32'd0);
    tick();
    check_eq("b_s3_o", 32'(o_b), 32'hD4);
`ifdef IO_REG_ROUTE_MUX_CNT_EN
    check_eq("b_cnt3", 32'(cnt_b), 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
